// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants and rotating priority encoder for stream muxes
//
// Purpose:
//   Mode encodings for stream_mux_n_1 and a rotating priority-encode function
//   that future arbiters can reuse. The function works on a fixed maximum
//   width (RR_MAX_CH). Callers zero-extend their request vector to that width
//   and keep the low bits of the result.
//
// Contents:
//   MODE_FIXED / MODE_RR  - values of the mode input
//   RR_MAX_CH / RR_IDX_W  - widest request vector the encoder supports
//   rot_pri_onehot()      - one-hot grant of the first request at or after ptr,
//                           with the search wrapping modulo n
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int RR_MAX_CH = 64;
  localparam int RR_IDX_W  = 6;

  // Search n request bits starting at index ptr and wrapping at n.
  // Returns a one-hot vector, or all-zero when no request is set.
  // ptr must be below n.
  function automatic logic [RR_MAX_CH-1:0] rot_pri_onehot(
    input logic [RR_MAX_CH-1:0] req,
    input int unsigned          ptr,
    input int unsigned          n
  );
    logic [RR_MAX_CH-1:0] g;
    logic                 found;
    int unsigned          idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX_CH; i++) begin
      if (i < n) begin
        // Wrap with a subtraction rather than a modulo; ptr < n keeps idx < 2n.
        idx = ptr + i;
        if (idx >= n) begin
          idx = idx - n;
        end
        if (!found && req[idx[RR_IDX_W-1:0]]) begin
          g[idx[RR_IDX_W-1:0]] = 1'b1;
          found                = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/stream_mux_rr_grant_n.sv
// rtl/stream_mux_rr_grant_n.sv - combinational round-robin grant for NUM_CH requesters
//
// Purpose:
//   Grants the first asserted request found by searching upward from i_ptr
//   and wrapping at NUM_CH. This module holds no state. The caller owns the
//   pointer and advances it.
//
// Ports:
//   i_req   [NUM_CH-1:0]  request vector, bit i = requester i
//   i_ptr   [SEL_W-1:0]   highest-priority index for this cycle
//   o_grant [NUM_CH-1:0]  one-hot grant, zero when no request is set
//
// NUM_CH must not exceed stream_mux_pkg::RR_MAX_CH.
module rr_grant_n
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [SEL_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_grant
);

  logic [RR_MAX_CH-1:0] w_req_ext;
  logic [RR_MAX_CH-1:0] w_grant_ext;

  assign w_req_ext   = RR_MAX_CH'(i_req);
  assign w_grant_ext = rot_pri_onehot(w_req_ext, 32'(i_ptr), NUM_CH);
  assign o_grant     = w_grant_ext[NUM_CH-1:0];

  // Bits above NUM_CH are always zero because their requests are zero.
  generate
    if (NUM_CH < RR_MAX_CH) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = |w_grant_ext[RR_MAX_CH-1:NUM_CH];
    end
  endgenerate

endmodule

// File: rtl/stream_mux_n_1.sv
// rtl/stream_mux_n_1.sv - registered N:1 stream multiplexer with fixed or round-robin select
//
// Purpose:
//   Selects one of NUM_CH valid/ready input channels and places the accepted
//   beat into a single registered output stage. When the consumer keeps
//   out_ready high, the block moves one beat per cycle.
//   mode selects the grant policy:
//     0 = fixed: the sel input chooses the channel.
//     1 = round-robin: search among valid channels starting at rr_ptr.
//
// Optional feature:
//   STREAM_MUX_PARITY_EN - adds out_par, the even-parity bit of the accepted
//   data. It is registered together with out_data.
//
// Ports:
//   clk                         rising-edge clock
//   rst                         synchronous, active-high reset
//   mode                        0 fixed select, 1 round-robin
//   sel       [SEL_W-1:0]       channel used in fixed mode
//   in_valid  [NUM_CH-1:0]      per-channel valid
//   in_data   [NUM_CH*W-1:0]    channel i at [i*W +: W]
//   in_ready  [NUM_CH-1:0]      per-channel ready (combinational, at most one high)
//   out_ready                   consumer ready
//   out_valid                   registered output valid
//   out_data  [W-1:0]           registered output data
//   out_ch    [SEL_W-1:0]       source channel of out_data
//   out_par                     (STREAM_MUX_PARITY_EN only) parity of out_data
module stream_mux_n_1
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int W      = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [NUM_CH-1:0]   in_valid,
  input  logic [NUM_CH*W-1:0] in_data,
  output logic [NUM_CH-1:0]   in_ready,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic [SEL_W-1:0]    out_ch
`ifdef STREAM_MUX_PARITY_EN
  ,
  output logic                out_par
`endif
);

  logic              r_out_valid;
  logic [W-1:0]      r_out_data;
  logic [SEL_W-1:0]  r_out_ch;
  logic [SEL_W-1:0]  r_rr_ptr;
`ifdef STREAM_MUX_PARITY_EN
  logic              r_out_par;
`endif

  logic              w_slot_free;
  logic [NUM_CH-1:0] w_fixed_grant;
  logic [NUM_CH-1:0] w_rr_grant;
  logic [NUM_CH-1:0] w_grant;
  logic [NUM_CH-1:0] w_accept;
  logic              w_xfer;
  logic [SEL_W-1:0]  w_acc_idx;
  logic [W-1:0]      w_acc_data;

  // The output register can take a new beat when it is empty, or when it
  // drains in this same cycle. The second case gives back-to-back throughput.
  assign w_slot_free = !r_out_valid || out_ready;

  // Fixed mode ignores in_valid. The granted channel sees in_ready even when
  // it has nothing to send. An out-of-range sel grants no channel.
  always_comb begin
    w_fixed_grant = '0;
    if (32'(sel) < NUM_CH) begin
      w_fixed_grant[sel] = 1'b1;
    end
  end

  rr_grant_n #(
    .NUM_CH (NUM_CH)
  ) u_rr_grant (
    .i_req   (in_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_rr_grant)
  );

  assign w_grant  = (mode == MODE_RR) ? w_rr_grant : w_fixed_grant;
  assign in_ready = (w_slot_free && !rst) ? w_grant : '0;
  assign w_accept = in_valid & in_ready;
  assign w_xfer   = |w_accept;

  // w_accept is one-hot or zero, so a plain priority scan gives its index.
  always_comb begin
    w_acc_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_accept[i]) begin
        w_acc_idx = SEL_W'(i);
      end
    end
  end

  assign w_acc_data = in_data[w_acc_idx*W +: W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= '0;
`ifdef STREAM_MUX_PARITY_EN
      r_out_par   <= 1'b0;
`endif
    end else if (w_xfer) begin
      // A new beat replaces the held one. This covers both the empty slot
      // and a simultaneous output transfer.
      r_out_valid <= 1'b1;
      r_out_data  <= w_acc_data;
      r_out_ch    <= w_acc_idx;
`ifdef STREAM_MUX_PARITY_EN
      r_out_par   <= ^w_acc_data;
`endif
      // Only round-robin grants move the pointer. A fixed-mode detour leaves
      // the fairness order where it was.
      if (mode == MODE_RR) begin
        r_rr_ptr <= (w_acc_idx == SEL_W'(NUM_CH - 1)) ? '0 : w_acc_idx + 1'b1;
      end
    end else if (out_ready) begin
      // The beat drained and nothing replaced it. Data and channel keep their
      // last values; only valid falls.
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
`ifdef STREAM_MUX_PARITY_EN
  assign out_par   = r_out_par;
`endif

endmodule

// File: tb/tb_stream_mux_n_1.sv
// tb/tb_stream_mux_n_1.sv - self-checking bench for stream_mux_n_1 with a behavioural model
module tb_stream_mux_n_1;

  localparam int NUM_CH = 4;
  localparam int W      = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
`ifdef STREAM_MUX_PARITY_EN
  logic        out_par;
`endif

  always #5 clk = ~clk;

  stream_mux_n_1 #(.NUM_CH(NUM_CH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch)
`ifdef STREAM_MUX_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: the contents of the output stage and the fairness pointer.
  bit         m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  int         m_ch    = 0;
  int         m_ptr   = 0;
  bit         m_par   = 1'b0;
  logic [3:0] exp_ready;

  function automatic logic [3:0] model_grant();
    logic [3:0] g;
    int c;
    g = 4'b0000;
    if (mode == 1'b0) begin
      if (sel < NUM_CH) g[sel] = 1'b1;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_ptr + k) % NUM_CH;
        if (in_valid[c]) begin
          g[c] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  // Let the combinational logic settle, then predict in_ready for this cycle.
  task automatic settle();
    #1;
    if (rst) exp_ready = 4'b0000;
    else if (!m_valid || out_ready) exp_ready = model_grant();
    else exp_ready = 4'b0000;
  endtask

  // Clock one edge and move the model to the state expected after that edge.
  task automatic tick();
    logic [3:0]  acc;
    logic [31:0] d;
    logic        md, ordy, r;
    int          c;
    acc  = in_valid & exp_ready;
    d    = in_data;
    md   = mode;
    ordy = out_ready;
    r    = rst;
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_ptr = 0; m_par = 1'b0;
    end else if (acc != 4'b0000) begin
      c = 0;
      for (int i = 0; i < NUM_CH; i++) if (acc[i]) c = i;
      m_data  = d[c*W +: W];
      m_ch    = c;
      m_valid = 1'b1;
      m_par   = ^m_data;
      if (md) m_ptr = (c + 1) % NUM_CH;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'b1111;
    in_data = 32'h13121110; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_vec++;
      if (in_ready !== 4'b0000) begin
        n_err++; $display("FAIL reset_in_ready got %b want 0000", in_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
        n_err++;
        $display("FAIL reset_outputs got v=%b d=%h ch=%0d want 0 00 0", out_valid, out_data, out_ch);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; in_data = 32'h13121110;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_vec++;
      if (in_ready !== 4'b0100 || in_ready !== exp_ready) begin
        n_err++; $display("FAIL fixed_in_ready cycle %0d got %b want 0100", i, in_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 8'h12 || out_ch !== 2'd2) begin
        n_err++;
        $display("FAIL fixed_out cycle %0d got v=%b d=%h ch=%0d want 1 12 2", i, out_valid, out_data, out_ch);
      end
    end
    sel = 2'd3; in_valid = 4'b0111;
    settle();
    n_vec++;
    if (in_ready !== 4'b1000) begin
      n_err++; $display("FAIL fixed_sel3_ready got %b want 1000", in_ready);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL fixed_drain got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_rr_fair();
    int want;
    mode = 1'b1; in_valid = 4'b1111; in_data = 32'hA3A2A1A0;
    for (int i = 0; i < 8; i++) begin
      settle(); tick();
      want = i % 4;
      n_vec++;
      if (out_valid !== 1'b1 || out_ch !== want[1:0] || out_data !== 8'hA0 + 8'(want)) begin
        n_err++;
        $display("FAIL rr_all beat %0d got v=%b ch=%0d d=%h want ch=%0d", i, out_valid, out_ch, out_data, want);
      end
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      settle(); tick();
      want = (i % 2 == 0) ? 1 : 3;
      n_vec++;
      if (out_ch !== want[1:0] || out_ch !== m_ch[1:0]) begin
        n_err++; $display("FAIL rr_1010 beat %0d got ch=%0d want %0d", i, out_ch, want);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; in_data = 32'h13121110; out_ready = 1'b1;
    settle(); tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_vec++;
      if (in_ready !== 4'b0000) begin
        n_err++; $display("FAIL bp_in_ready cycle %0d got %b want 0000", i, in_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 8'h12 || out_ch !== 2'd2) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d got v=%b d=%h ch=%0d want 1 12 2", i, out_valid, out_data, out_ch);
      end
    end
    out_ready = 1'b1; in_data = 32'h13221110;
    settle();
    n_vec++;
    if (in_ready !== 4'b0100) begin
      n_err++; $display("FAIL bp_release_ready got %b want 0100", in_ready);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h22) begin
      n_err++; $display("FAIL bp_no_bubble got v=%b d=%h want 1 22", out_valid, out_data);
    end
  endtask

  task automatic test_mode_switch();
    int seq [6] = '{0, 1, 2, 1, 3, 0};
    int want;
    in_valid = 4'b1111; in_data = 32'hB3B2B1B0;
    for (int i = 0; i < 6; i++) begin
      mode = (i == 3) ? 1'b0 : 1'b1;
      sel  = 2'd1;
      settle(); tick();
      want = seq[i];
      n_vec++;
      if (out_ch !== want[1:0] || out_data !== 8'hB0 + 8'(want)) begin
        n_err++; $display("FAIL mode_switch step %0d got ch=%0d d=%h want ch=%0d", i, out_ch, out_data, want);
      end
    end
  endtask

`ifdef STREAM_MUX_PARITY_EN
  task automatic test_parity();
    logic [7:0] vals [2] = '{8'h07, 8'h03};
    logic       want [2] = '{1'b1, 1'b0};
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = {24'h0, vals[i]};
      settle(); tick();
      n_vec++;
      if (out_par !== want[i] || out_data !== vals[i]) begin
        n_err++; $display("FAIL parity data %h got par=%b want %b", vals[i], out_par, want[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      settle();
      n_vec++;
      if (in_ready !== exp_ready) begin
        n_err++; $display("FAIL rand_ready cycle %0d got %b want %b", i, in_ready, exp_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== m_valid || out_data !== m_data || out_ch !== m_ch[1:0]) begin
        n_err++;
        $display("FAIL rand_out cycle %0d got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                 i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
      end
`ifdef STREAM_MUX_PARITY_EN
      n_vec++;
      if (out_par !== m_par) begin
        n_err++; $display("FAIL rand_par cycle %0d got %b want %b", i, out_par, m_par);
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_fair();
    test_backpressure();
    test_mode_switch();
`ifdef STREAM_MUX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
